// File: rtl/reg_dump_uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : reg_dump_uart_pkg                                                |
// | Purpose : Shared constants, FSM state encoding and the hex-to-ASCII        |
// |           helper for the register-dump debug port.                         |
// | Ports   : none (package)                                                   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package reg_dump_uart_pkg;

  localparam logic [7:0] c_ASCII_CR = 8'h0D;
  localparam logic [7:0] c_ASCII_LF = 8'h0A;
  localparam logic [7:0] c_ASCII_0  = 8'h30;
  localparam logic [7:0] c_ASCII_A  = 8'h41;

  // Characters per register line: 8 hex digits, CR, LF.
  localparam int c_CHARS_PER_REG = 10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SET_ADDR = 3'd1,
    ST_CAPTURE  = 3'd2,
    ST_SEND     = 3'd3,
    ST_NEXT_REG = 3'd4,
    ST_FINISH   = 3'd5
  } dumpState_t;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] hexChar(input logic [3:0] nibble);
    logic [7:0] w_char;
    if (nibble < 4'd10) begin
      w_char = c_ASCII_0 + {4'd0, nibble};
    end else begin
      w_char = c_ASCII_A + {4'd0, nibble} - 8'd10;
    end
    return w_char;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_tx_byte                                                     |
// | Purpose : 8N1 UART transmitter for a single byte with a valid/ready        |
// |           handshake. ready rises in the last cycle of the stop bit so a    |
// |           parent can chain bytes with no idle gap.                         |
// | Ports   : clock, reset (async, active-high), data[7:0], valid  -> in       |
// |           ready, tx (idle high)                                  -> out     |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int                 c_CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST_CLK = c_CNT_W'(CLKS_PER_BIT - 1);

  // Whole frame held in one shift register; bit 0 is always the line level.
  // Shifting in ones leaves the line idle-high once the stop bit is gone.
  logic [9:0]         r_frame;
  logic [3:0]         r_bitIdx;
  logic [c_CNT_W-1:0] r_clkCnt;
  logic               r_active;
  logic               w_lastCycle;
  logic               w_accept;

  assign w_lastCycle = r_active && (r_bitIdx == 4'd9) && (r_clkCnt == c_LAST_CLK);
  assign ready       = !r_active || w_lastCycle;
  assign w_accept    = valid && ready;
  assign tx          = r_frame[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_frame  <= '1;
      r_bitIdx <= 4'd0;
      r_clkCnt <= '0;
      r_active <= 1'b0;
    end else if (w_accept) begin
      r_frame  <= {1'b1, data, 1'b0};
      r_bitIdx <= 4'd0;
      r_clkCnt <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_clkCnt == c_LAST_CLK) begin
        r_clkCnt <= '0;
        r_frame  <= {1'b1, r_frame[9:1]};
        if (r_bitIdx == 4'd9) begin
          r_active <= 1'b0;
        end else begin
          r_bitIdx <= r_bitIdx + 4'd1;
        end
      end else begin
        r_clkCnt <= r_clkCnt + c_CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_dump_uart.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : reg_dump_uart                                                    |
// | Purpose : Debug-port initiator: on start, walks x0..x(NUM_REGS-1) through  |
// |           readFPGA, snapshots regFPGA and sends each value over UART as    |
// |           8 uppercase hex characters followed by CR LF.                    |
// | Ports   : clock, reset (async, active-high), start, regFPGA[31:0] -> in    |
// |           readFPGA[4:0], tx, busy, done                         -> out     |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module reg_dump_uart
  import reg_dump_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_REGS     = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] regFPGA,
  output logic [4:0]  readFPGA,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int                   c_FRAME_CLKS = 10 * CLKS_PER_BIT;
  localparam int                   c_DRAIN_W    = $clog2(c_FRAME_CLKS);
  // Leaving NEXT_REG here puts SET_ADDR in the last stop-bit cycle of the
  // LF, so the next register's first start bit follows after two idle cycles.
  localparam logic [c_DRAIN_W-1:0] c_DRAIN_END  = c_DRAIN_W'(c_FRAME_CLKS - 2);
  localparam logic [4:0]           c_LAST_IDX   = 5'(NUM_REGS - 1);
  localparam logic [3:0]           c_LAST_CHAR  = 4'(c_CHARS_PER_REG - 1);

  dumpState_t           r_state;
  dumpState_t           w_nextState;
  logic [4:0]           r_idx;
  logic [3:0]           r_charCnt;
  logic [31:0]          r_snap;
  logic [c_DRAIN_W-1:0] r_drainCnt;

  logic                 w_txValid;
  logic                 w_txReady;
  logic [7:0]           w_txData;
  logic [4:0]           w_shift;
  logic [3:0]           w_nibble;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_txValid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_nextState = ST_SET_ADDR;
      end
      ST_SET_ADDR: w_nextState = ST_CAPTURE;
      ST_CAPTURE:  w_nextState = ST_SEND;
      ST_SEND: begin
        w_txValid = 1'b1;
        if (w_txReady && (r_charCnt == c_LAST_CHAR)) w_nextState = ST_NEXT_REG;
      end
      ST_NEXT_REG: begin
        // The final register waits for the whole LF frame so done lands
        // after its stop bit; others overlap the fetch with the stop bit.
        if (r_idx == c_LAST_IDX) begin
          if (w_txReady) w_nextState = ST_FINISH;
        end else if (r_drainCnt == c_DRAIN_END) begin
          w_nextState = ST_SET_ADDR;
        end
      end
      ST_FINISH:   w_nextState = ST_IDLE;
      default:     w_nextState = ST_IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx      <= 5'd0;
      r_charCnt  <= 4'd0;
      r_snap     <= 32'd0;
      r_drainCnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: r_idx <= 5'd0;
        ST_CAPTURE: begin
          r_snap    <= regFPGA;
          r_charCnt <= 4'd0;
        end
        ST_SEND: begin
          if (w_txReady) begin
            r_charCnt  <= r_charCnt + 4'd1;
            r_drainCnt <= '0;
          end
        end
        ST_NEXT_REG: begin
          r_drainCnt <= r_drainCnt + c_DRAIN_W'(1);
          if (w_nextState == ST_SET_ADDR) r_idx <= r_idx + 5'd1;
        end
        ST_FINISH: r_idx <= 5'd0;
        default: ;
      endcase
    end
  end

  // Character 0 is the most significant nibble.
  assign w_shift  = {3'd7 - r_charCnt[2:0], 2'b00};
  assign w_nibble = 4'(r_snap >> w_shift);

  always_comb begin
    w_txData = hexChar(w_nibble);
    if (r_charCnt == 4'd8) w_txData = c_ASCII_CR;
    if (r_charCnt == 4'd9) w_txData = c_ASCII_LF;
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uartTx (
    .clock(clock),
    .reset(reset),
    .data (w_txData),
    .valid(w_txValid),
    .ready(w_txReady),
    .tx   (tx)
  );

  assign readFPGA = r_idx;
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_FINISH);

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_uart.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_reg_dump_uart                                                 |
// | Purpose : Self-checking bench for reg_dump_uart. Two DUTs share a clock:   |
// |           index 0 has NUM_REGS=1, index 1 has NUM_REGS=32 (reg[i]=i).      |
// |           Expected bytes are queued per DUT; a UART monitor decodes tx     |
// |           and compares against the queue.                                  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_reg_dump_uart;

  localparam int c_CPB = 4;

  logic        clk;
  logic [1:0]  rstV;
  logic [1:0]  startV;
  logic [31:0] reg0Val;
  logic [31:0] regOne;
  logic [31:0] regThirty;
  logic [4:0]  readOne;
  logic [4:0]  readThirty;
  logic        txOne, txThirty, busyOne, busyThirty, doneOne, doneThirty;
  logic [1:0]  txV, busyV, doneV;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  int         mState[2];
  int         mCnt[2];
  logic [7:0] mByte[2];
  int         idleCnt[2];
  logic       prevLF[2];
  logic       frameSeen[2];
  logic       sawDone[2];
  int         doneCnt[2];
  logic [4:0] lastRa;
  int         raSteps;

  assign txV    = {txThirty, txOne};
  assign busyV  = {busyThirty, busyOne};
  assign doneV  = {doneThirty, doneOne};
  assign regOne    = (readOne == 5'd0) ? reg0Val : 32'hBAD0_0000;
  assign regThirty = {27'd0, readThirty};

  reg_dump_uart #(.CLKS_PER_BIT(c_CPB), .NUM_REGS(1)) u_dutOne (
    .clock(clk), .reset(rstV[0]), .start(startV[0]), .regFPGA(regOne),
    .readFPGA(readOne), .tx(txOne), .busy(busyOne), .done(doneOne));

  reg_dump_uart #(.CLKS_PER_BIT(c_CPB), .NUM_REGS(32)) u_dutThirty (
    .clock(clk), .reset(rstV[1]), .start(startV[1]), .regFPGA(regThirty),
    .readFPGA(readThirty), .tx(txThirty), .busy(busyThirty), .done(doneThirty));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hexAscii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
  endfunction

  task automatic pushByte(input int w, input logic [7:0] b);
    if (w == 0) q0.push_back(b);
    else        q1.push_back(b);
  endtask

  task automatic pushReg(input int w, input logic [31:0] val);
    for (int i = 7; i >= 0; i--) pushByte(w, hexAscii(val[i*4 +: 4]));
    pushByte(w, 8'h0D);
    pushByte(w, 8'h0A);
  endtask

  function automatic int qSize(input int w);
    return (w == 0) ? q0.size() : q1.size();
  endfunction

  // ------------------------------------------------------------ monitor
  task automatic byteDone(input int w);
    logic [7:0] exp;
    check($sformatf("stopBit%0d", w), {31'd0, txV[w]}, 32'd1);
    if (qSize(w) == 0) begin
      checks++;
      failures++;
      $display("FAIL extraByte dut%0d: got %02h expected none", w, mByte[w]);
    end else begin
      exp = (w == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("byte%0d", w), {24'd0, mByte[w]}, {24'd0, exp});
    end
    prevLF[w]    = (mByte[w] == 8'h0A);
    frameSeen[w] = 1'b1;
    sawDone[w]   = 1'b0;
    idleCnt[w]   = 0;
    mState[w]    = 0;
  endtask

  task automatic monStep(input int w);
    if (rstV[w]) begin
      mState[w] = 0; mCnt[w] = 0; idleCnt[w] = 0;
      prevLF[w] = 1'b0; frameSeen[w] = 1'b0; sawDone[w] = 1'b0;
      if (w == 1) lastRa = 5'd0;
    end else begin
      if (doneV[w]) begin
        doneCnt[w]++;
        sawDone[w] = 1'b1;
      end
      if (w == 1) begin
        if (!busyV[1]) lastRa = 5'd0;
        else if (readThirty != lastRa) begin
          check("raStep", {27'd0, readThirty}, {27'd0, lastRa} + 32'd1);
          lastRa = readThirty;
          raSteps++;
        end
      end
      if (mState[w] == 0) begin
        if (txV[w] == 1'b0) begin
          // Idle cycles seen include the last stop-bit cycle of the previous frame.
          if (frameSeen[w] && !sawDone[w])
            check($sformatf("gap%0d", w), idleCnt[w], prevLF[w] ? 32'd3 : 32'd1);
          mState[w] = 1; mCnt[w] = 0; mByte[w] = 8'h00;
        end else begin
          idleCnt[w]++;
        end
      end else begin
        mCnt[w]++;
        if (mCnt[w] == 2) check($sformatf("startBit%0d", w), {31'd0, txV[w]}, 32'd0);
        else if (mCnt[w] >= 6 && mCnt[w] <= 34 && (mCnt[w] % c_CPB) == 2)
          mByte[w][(mCnt[w] - 6) / c_CPB] = txV[w];
        else if (mCnt[w] == 38) byteDone(w);
      end
    end
  endtask

  initial begin
    for (int w = 0; w < 2; w++) begin
      mState[w] = 0; mCnt[w] = 0; idleCnt[w] = 0; doneCnt[w] = 0;
      prevLF[w] = 1'b0; frameSeen[w] = 1'b0; sawDone[w] = 1'b0; mByte[w] = 8'h00;
    end
    lastRa  = 5'd0;
    raSteps = 0;
    forever begin
      @(negedge clk);
      for (int w = 0; w < 2; w++) monStep(w);
    end
  end

  // ------------------------------------------------------------ helpers
  task automatic pulseStart(input int w);
    @(posedge clk); #1 startV[w] = 1'b1;
    @(posedge clk); #1 startV[w] = 1'b0;
  endtask

  task automatic waitIdle(input int w, input int maxCyc, input string name);
    int n = 0;
    while (busyV[w] && n < maxCyc) begin @(negedge clk); n++; end
    check(name, {31'd0, busyV[w]}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic waitRa(input logic [4:0] val, input int maxCyc);
    int n = 0;
    while (readThirty != val && n < maxCyc) begin @(negedge clk); n++; end
    check("waitRa", {27'd0, readThirty}, {27'd0, val});
  endtask

  task automatic waitQEmpty(input int w, input int maxCyc);
    int n = 0;
    while (qSize(w) != 0 && n < maxCyc) begin @(negedge clk); n++; end
    check("queueDrain", qSize(w), 32'd0);
  endtask

  // ------------------------------------------------------------ stimulus
  logic [7:0] exp7  [10];
  logic [7:0] expDb [10];
  logic [7:0] expCf [10];

  initial begin
    exp7  = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h37, 8'h0D, 8'h0A};
    expDb = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    expCf = '{8'h43, 8'h41, 8'h46, 8'h45, 8'h30, 8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A};
    rstV    = 2'b11;
    startV  = 2'b00;
    reg0Val = 32'd0;

    // Reset values appear before any clock edge.
    #1;
    for (int w = 0; w < 2; w++) begin
      check($sformatf("rstTx%0d", w),   {31'd0, txV[w]},   32'd1);
      check($sformatf("rstBusy%0d", w), {31'd0, busyV[w]}, 32'd0);
      check($sformatf("rstDone%0d", w), {31'd0, doneV[w]}, 32'd0);
    end
    check("rstRead0", {27'd0, readOne},    32'd0);
    check("rstRead1", {27'd0, readThirty}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rstV = 2'b00;

    // NUM_REGS=1, value 7, with start-to-start-bit latency.
    reg0Val = 32'h0000_0007;
    for (int i = 0; i < 10; i++) pushByte(0, exp7[i]);
    @(posedge clk); #1 startV[0] = 1'b1;
    @(posedge clk); #1 startV[0] = 1'b0;
    check("busyRise", {31'd0, busyOne}, 32'd1);
    check("lat0", {31'd0, txOne}, 32'd1);
    @(posedge clk); #1 check("lat1", {31'd0, txOne}, 32'd1);
    @(posedge clk); #1 check("lat2", {31'd0, txOne}, 32'd1);
    @(posedge clk); #1 check("lat3", {31'd0, txOne}, 32'd0);
    waitIdle(0, 800, "dump7Idle");
    check("done7", doneCnt[0], 32'd1);
    check("q7", qSize(0), 32'd0);
    check("read0Idle", {27'd0, readOne}, 32'd0);

    // DEADBEEF; the source changes right after the snapshot edge.
    reg0Val = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) pushByte(0, expDb[i]);
    @(posedge clk); #1 startV[0] = 1'b1;
    @(posedge clk); #1 startV[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 reg0Val = 32'd0;
    waitIdle(0, 800, "dumpDbIdle");
    check("doneDb", doneCnt[0], 32'd2);
    check("qDb", qSize(0), 32'd0);

    // Full 32-register dump with ignored start pulses.
    for (int i = 0; i < 32; i++) pushReg(1, i);
    pulseStart(1);
    waitRa(5'd5, 5000);
    pulseStart(1);
    waitRa(5'd9, 5000);
    @(posedge clk); #1 startV[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1 startV[1] = 1'b0;
    waitRa(5'd31, 20000);
    // Hold start across FINISH: the second dump restarts at x0.
    pushReg(1, 32'd0);
    @(posedge clk); #1 startV[1] = 1'b1;
    begin
      int n = 0;
      while (!doneThirty && n < 2000) begin @(negedge clk); n++; end
    end
    check("done32", {31'd0, doneThirty}, 32'd1);
    @(negedge clk);
    check("busyFall", {31'd0, busyThirty}, 32'd0);
    check("read1Idle", {27'd0, readThirty}, 32'd0);
    @(negedge clk);
    check("restart", {31'd0, busyThirty}, 32'd1);
    check("doneCnt32", doneCnt[1], 32'd1);
    check("raSteps", raSteps, 32'd31);
    @(posedge clk); #1 startV[1] = 1'b0;
    waitQEmpty(1, 1000);
    @(posedge clk); #2 rstV[1] = 1'b1;
    #1;
    check("abortTx1", {31'd0, txThirty}, 32'd1);
    check("abortBusy1", {31'd0, busyThirty}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rstV[1] = 1'b0;
    check("doneCnt32b", doneCnt[1], 32'd1);

    // Reset during the third data bit of the fifth byte.
    reg0Val = 32'hCAFE_0123;
    for (int i = 0; i < 4; i++) pushByte(0, expCf[i]);
    @(posedge clk); #1 startV[0] = 1'b1;
    @(posedge clk); #1 startV[0] = 1'b0;
    repeat (3 + 4 * 10 * c_CPB + 3 * c_CPB + 1) @(posedge clk);
    #2 check("preRstTx", {31'd0, txOne}, 32'd0);
    rstV[0] = 1'b1;
    #1;
    check("midRstTx", {31'd0, txOne}, 32'd1);
    check("midRstBusy", {31'd0, busyOne}, 32'd0);
    check("midRstDone", {31'd0, doneOne}, 32'd0);
    check("midRstRead", {27'd0, readOne}, 32'd0);
    check("abortQ", qSize(0), 32'd0);
    repeat (3) @(posedge clk);
    #1 rstV[0] = 1'b0;
    check("noDoneAbort", doneCnt[0], 32'd2);
    for (int i = 0; i < 10; i++) pushByte(0, expCf[i]);
    pulseStart(0);
    waitIdle(0, 800, "dumpCfIdle");
    check("doneCf", doneCnt[0], 32'd3);
    check("qCf", qSize(0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
